sfx_player: RTL

Sound-effect sequencer for the whack-a-mole audio path. On a game-event pulse (hit, miss, game over) it steps through a fixed note sequence from an internal ROM. It drives `note_div_left`, `note_div_right` and `amplitude` directly into the buzzer/note generator, with a per-tick decaying envelope. The output encoding matches the note generator: div value 1 means silence; a square wave toggles every div+1 clocks.

---
 rtl/sfx_player.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sfx_player.sv
// sfx_player: sound-effect sequencer for the whack-a-mole buzzer.
// A game-event pulse plays a short note sequence from an internal ROM.
// The envelope decays once per tick, and all outputs are registered.
module sfx_player #(
    parameter int          TICK_DIV    = 1_000_000,
    parameter logic [15:0] AMP_MAX     = 16'h2000,
    parameter int          DECAY_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_hit,
    input  logic        trig_miss,
    input  logic        trig_over,
    input  logic        mute,
    output logic [21:0] note_div_left,
    output logic [21:0] note_div_right,
    output logic [15:0] amplitude,
    output logic        busy
);

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [21:0]    DIV_SILENT = 22'd1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

    // The sequence id doubles as its priority: hit=1, miss=2, over=3
    localparam logic [1:0] SEQ_NONE = 2'd0;
    localparam logic [1:0] SEQ_HIT  = 2'd1;
    localparam logic [1:0] SEQ_MISS = 2'd2;
    localparam logic [1:0] SEQ_OVER = 2'd3;

    // ROM entry packing: {note code[2:0], duration[3:0], last flag}
    function automatic logic [7:0] rom_entry(input logic [1:0] seq, input logic [2:0] idx);
        logic [7:0] e;
        case ({seq, idx})
            {SEQ_HIT,  3'd0}: e = {3'd1, 4'd2, 1'b0};
            {SEQ_HIT,  3'd1}: e = {3'd2, 4'd2, 1'b0};
            {SEQ_HIT,  3'd2}: e = {3'd3, 4'd2, 1'b0};
            {SEQ_HIT,  3'd3}: e = {3'd4, 4'd4, 1'b1};
            {SEQ_MISS, 3'd0}: e = {3'd5, 4'd4, 1'b0};
            {SEQ_MISS, 3'd1}: e = {3'd6, 4'd6, 1'b1};
            {SEQ_OVER, 3'd0}: e = {3'd3, 4'd4, 1'b0};
            {SEQ_OVER, 3'd1}: e = {3'd2, 4'd4, 1'b0};
            {SEQ_OVER, 3'd2}: e = {3'd1, 4'd4, 1'b0};
            {SEQ_OVER, 3'd3}: e = {3'd0, 4'd2, 1'b0};
            {SEQ_OVER, 3'd4}: e = {3'd6, 4'd8, 1'b1};
            default:          e = {3'd0, 4'd1, 1'b1};
        endcase
        return e;
    endfunction

    // Divider values for a 100 MHz clock: floor(50e6/f) - 1; code 0 is a rest
    function automatic logic [21:0] note_div(input logic [2:0] code);
        logic [21:0] d;
        case (code)
            3'd1:    d = 22'd95_601;
            3'd2:    d = 22'd75_871;
            3'd3:    d = 22'd63_774;
            3'd4:    d = 22'd47_754;
            3'd5:    d = 22'd127_550;
            3'd6:    d = 22'd190_838;
            default: d = DIV_SILENT;
        endcase
        return d;
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     seq_q, seq_d;
    logic [2:0]     idx_q, idx_d;
    logic [3:0]     remain_q, remain_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [21:0]    div_q, div_d;
    logic [15:0]    env_q, env_d;
    logic [21:0]    div_left_q, div_left_d;
    logic [21:0]    div_right_q, div_right_d;
    logic [15:0]    amp_q, amp_d;
    logic           busy_q, busy_d;

    logic [1:0]     trig_pri;
    logic           accept;
    logic           tick_wrap;
    logic [7:0]     entry_cur, entry_next, entry_first;

    // Next-state logic: trigger arbitration, tick counting, note stepping and envelope decay
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        remain_d = remain_q;
        tick_d   = tick_q;
        div_d    = div_q;
        env_d    = env_q;

        if (trig_over)      trig_pri = SEQ_OVER;
        else if (trig_miss) trig_pri = SEQ_MISS;
        else if (trig_hit)  trig_pri = SEQ_HIT;
        else                trig_pri = SEQ_NONE;

        accept      = (trig_pri != SEQ_NONE) && ((state_q == S_IDLE) || (trig_pri >= seq_q));
        tick_wrap   = (tick_q == TICK_LAST);
        entry_cur   = rom_entry(seq_q, idx_q);
        entry_next  = rom_entry(seq_q, idx_q + 3'd1);
        entry_first = rom_entry(seq_q, 3'd0);

        if (accept) begin
            // The old note keeps sounding through the cycle spent in LOAD
            state_d = S_LOAD;
            seq_d   = trig_pri;
            idx_d   = 3'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    state_d  = S_PLAY;
                    idx_d    = 3'd0;
                    tick_d   = '0;
                    div_d    = note_div(entry_first[7:5]);
                    env_d    = (entry_first[7:5] == 3'd0) ? 16'd0 : AMP_MAX;
                    remain_d = entry_first[4:1];
                end
                S_PLAY: begin
                    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                    if (tick_wrap) begin
                        if (remain_q > 4'd1) begin
                            remain_d = remain_q - 4'd1;
                            env_d    = env_q - (env_q >> DECAY_SHIFT);
                        end else if (!entry_cur[0]) begin
                            idx_d    = idx_q + 3'd1;
                            div_d    = note_div(entry_next[7:5]);
                            env_d    = (entry_next[7:5] == 3'd0) ? 16'd0 : AMP_MAX;
                            remain_d = entry_next[4:1];
                        end else begin
                            state_d  = S_IDLE;
                            seq_d    = SEQ_NONE;
                            idx_d    = 3'd0;
                            remain_d = 4'd0;
                            div_d    = DIV_SILENT;
                            env_d    = 16'd0;
                        end
                    end
                end
                default: begin
                    tick_d = '0;
                end
            endcase
        end

        busy_d      = (state_d != S_IDLE);
        div_left_d  = mute ? DIV_SILENT : div_d;
        amp_d       = mute ? 16'd0 : env_d;
        div_right_d = (div_left_d == DIV_SILENT) ? DIV_SILENT : {div_left_d[20:0], 1'b1};
    end

    // State and output registers with synchronous reset to silence
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seq_q       <= SEQ_NONE;
            idx_q       <= 3'd0;
            remain_q    <= 4'd0;
            tick_q      <= '0;
            div_q       <= DIV_SILENT;
            env_q       <= 16'd0;
            div_left_q  <= DIV_SILENT;
            div_right_q <= DIV_SILENT;
            amp_q       <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;
            remain_q    <= remain_d;
            tick_q      <= tick_d;
            div_q       <= div_d;
            env_q       <= env_d;
            div_left_q  <= div_left_d;
            div_right_q <= div_right_d;
            amp_q       <= amp_d;
            busy_q      <= busy_d;
        end
    end

    assign note_div_left  = div_left_q;
    assign note_div_right = div_right_q;
    assign amplitude      = amp_q;
    assign busy           = busy_q;

endmodule
